charge_init_sequencer: RTL and testbench
========================================

// Module: charge_init_sequencer
// PURPOSE
//  Drives the 14-bit control word consumed by charge_control, standing in for the AWG's
//  control lines. Runs repeated charge-initialization attempts (reset, sequence pulses,
//  count window) and reads the 15-bit status bus returned by charge_control. Stops on
//  threshold success or when the attempt limit is reached, then reports the captured
//  counts and sequence position to the host.
// PARAMETERS
//  CNT_W        16  width of count_window / window counter
//  ATT_W         6  width of max_attempts / attempts (<=6 so attempts fit seq_pos[5:0])
//  RESET_CYCLES  4  cycles ctrl_out[1] held high per attempt (>=1)
//  SETTLE_CYCLES 2  cycles to wait after count_on falls before sampling awg_in (>=1)
// PORTS
//  S_AXI_ACLK     in   1      sole clock
//  S_AXI_ARESETN  in   1      asynchronous, active-low reset
//  start          in   1      1-cycle request; ignored while busy
//  routine        in   2      latched at start -> ctrl_out[5:4]; 00 dynamic stop, else full window
//  thr0           in   2      latched at start -> ctrl_out[8:7]
//  thr1           in   2      latched at start -> ctrl_out[10:9]
//  count_window   in   CNT_W  count_on high time per attempt, in cycles; 0 treated as 1
//  max_attempts   in   ATT_W  attempt limit; 0 treated as 1
//  awg_in         in   15     status from charge_control ([2] thr hit, [8:3] counts, [14:9] seq)
//  ctrl_out       out  14     [0] enable, [1] reset, [2] count_on, [3] 0, [5:4] routine,
//                             [6] seq pulse, [8:7] thr0, [10:9] thr1, [13:11] 0
//  busy           out  1      high from the cycle after accepted start until done
//  done           out  1      1-cycle pulse at end of run
//  success        out  1      valid with done, held until next start
//  attempts       out  ATT_W  attempts used (1-based), held until next start
//  last_counts    out  6      awg_in[8:3] sampled in the last CAPTURE
//  last_seq       out  6      awg_in[14:9] sampled in the last CAPTURE
//  seq_mismatch   out  1      last_seq != attempts at CAPTURE; sticky until next start
// BEHAVIOUR
//  - Reset (any time, including mid-run): state IDLE; all outputs, counters and latches 0.
//  - awg_in is registered once; all decisions use the registered copy (1-cycle latency).
//  - IDLE: ctrl_out = 0. An accepted start latches routine/thr0/thr1/count_window/
//    max_attempts (zero-substituted), clears the result outputs, sets attempts=1 -> RST.
//  - RST: ctrl_out[1]=1 and [0]=0 for RESET_CYCLES cycles -> SEQ.
//  - SEQ: enable=1; emits `attempts` pulses on ctrl_out[6], each 1 cycle high and 1 cycle
//    low, with count_on=0, so that charge_control's seq_pos equals the attempt number -> COUNT.
//  - COUNT: enable=1, count_on=1, window counter counts count_window cycles. Sets hit_flag
//    on registered awg_in[2]. If routine==00 and hit_flag is set, leave early. Otherwise
//    leave after the full window -> CAPTURE.
//  - CAPTURE: enable=1, count_on=0 for SETTLE_CYCLES. hit_flag is still updated during
//    these cycles. On the final cycle, sample last_counts and last_seq and update
//    seq_mismatch -> DECIDE.
//  - DECIDE (1 cycle):
//      hit_flag                   -> DONE with success=1
//      attempts == max_attempts   -> DONE with success=0
//      otherwise                  -> attempts+1, hit_flag cleared -> RST
//  - DONE: done=1 for 1 cycle; enable stays 1 so charge_control holds awg_out -> IDLE.
//  - thr0, thr1 and routine fields are driven continuously from the latches in every
//    non-IDLE state.
//  - attempts never wraps: max_attempts <= 2^ATT_W-1.
//  - start coinciding with DONE is ignored; start on the cycle IDLE is entered is accepted.
//  - count_window = 1: count_on is high for exactly 1 cycle.
// TESTING
//  1 routine=00, window=100, thr hit at cycle 10 of COUNT -> count_on high ~11 cycles,
//    done with success=1, attempts=1, last_seq=1.
//  2 routine=11, window=50, hit at cycle 5 -> count_on high for exactly 50 cycles,
//    success=1.
//  3 max_attempts=3, awg_in[2] never asserted -> 3 RST pulses; SEQ pulse counts 1,2,3;
//    success=0, attempts=3.
//  4 Model returns awg_in[14:9]=0 -> seq_mismatch=1. Correct model -> seq_mismatch=0.
//  5 S_AXI_ARESETN low mid-COUNT -> ctrl_out=0, busy=0 at once; start after release
//    runs normally.
//  6 window=0, max_attempts=0 -> one attempt with a 1-cycle count_on. start while busy
//    -> no effect.

Source files
------------

// File: rtl/charge_init_sequencer.sv
// Charge-initialization sequencer: drives the charge_control control word through repeated
// reset / sequence-pulse / count-window attempts and reports the captured status to the host.
module charge_init_sequencer #(
  parameter int CNT_W         = 16,
  parameter int ATT_W         = 6,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             start,
  input  logic [1:0]       routine,
  input  logic [1:0]       thr0,
  input  logic [1:0]       thr1,
  input  logic [CNT_W-1:0] count_window,
  input  logic [ATT_W-1:0] max_attempts,
  input  logic [14:0]      awg_in,
  output logic [13:0]      ctrl_out,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic [ATT_W-1:0] attempts,
  output logic [5:0]       last_counts,
  output logic [5:0]       last_seq,
  output logic             seq_mismatch
);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared counter serves the reset hold, the 2*attempts sequence phases, the window and settling.
  localparam int CW = max_i(max_i(CNT_W, ATT_W + 1),
                            max_i($clog2(RESET_CYCLES + 1), $clog2(SETTLE_CYCLES + 1)));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RST     = 3'd1,
    S_SEQ     = 3'd2,
    S_COUNT   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DECIDE  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       routine_q, routine_d;
  logic [1:0]       thr0_q, thr0_d;
  logic [1:0]       thr1_q, thr1_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [ATT_W-1:0] max_q, max_d;
  logic [ATT_W-1:0] attempts_q, attempts_d;
  logic             hit_q, hit_d;
  logic [14:0]      awg_q, awg_d;
  logic [13:0]      ctrl_q, ctrl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             success_q, success_d;
  logic [5:0]       last_counts_q, last_counts_d;
  logic [5:0]       last_seq_q, last_seq_d;
  logic             mismatch_q, mismatch_d;
  logic             hit_now_s;
  logic [CW-1:0]    win_end_s;
  logic [CW-1:0]    seq_end_s;
  logic             unused_awg_s;

  // Bits [1:0] of the status bus carry nothing this sequencer acts on.
  assign unused_awg_s = ^awg_q[1:0];

  function automatic logic [13:0] ctrl_word(input state_t st, input logic seq_phase,
                                            input logic [1:0] rt, input logic [1:0] t0,
                                            input logic [1:0] t1);
    logic [13:0] w;
    w = 14'd0;
    case (st)
      S_IDLE:    w = 14'd0;
      S_RST:     w[1] = 1'b1;
      S_SEQ:     begin w[0] = 1'b1; w[6] = ~seq_phase; end
      S_COUNT:   begin w[0] = 1'b1; w[2] = 1'b1; end
      S_CAPTURE: w[0] = 1'b1;
      S_DECIDE:  w[0] = 1'b1;
      S_DONE:    w[0] = 1'b1;
      default:   w = 14'd0;
    endcase
    if (st != S_IDLE) begin
      w[5:4]  = rt;
      w[8:7]  = t0;
      w[10:9] = t1;
    end else begin
      w = 14'd0;
    end
    return w;
  endfunction

  // Next-state, counter, latch and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    routine_d     = routine_q;
    thr0_d        = thr0_q;
    thr1_d        = thr1_q;
    win_d         = win_q;
    max_d         = max_q;
    attempts_d    = attempts_q;
    hit_d         = hit_q;
    awg_d         = awg_in;
    success_d     = success_q;
    last_counts_d = last_counts_q;
    last_seq_d    = last_seq_q;
    mismatch_d    = mismatch_q;
    hit_now_s     = hit_q | awg_q[2];
    win_end_s     = CW'(win_q) - CW'(1);
    seq_end_s     = CW'({attempts_q, 1'b0}) - CW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          routine_d     = routine;
          thr0_d        = thr0;
          thr1_d        = thr1;
          win_d         = (count_window == {CNT_W{1'b0}}) ? CNT_W'(1) : count_window;
          max_d         = (max_attempts == {ATT_W{1'b0}}) ? ATT_W'(1) : max_attempts;
          attempts_d    = ATT_W'(1);
          hit_d         = 1'b0;
          success_d     = 1'b0;
          last_counts_d = 6'd0;
          last_seq_d    = 6'd0;
          mismatch_d    = 1'b0;
          cnt_d         = {CW{1'b0}};
          state_d       = S_RST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RST: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_SEQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEQ: begin
        if (cnt_q == seq_end_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_COUNT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_COUNT: begin
        hit_d = hit_now_s;
        // Dynamic-stop routine leaves as soon as the threshold hit is visible.
        if (((routine_q == 2'b00) && hit_now_s) || (cnt_q == win_end_s)) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        hit_d = hit_now_s;
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          last_counts_d = awg_q[8:3];
          last_seq_d    = awg_q[14:9];
          mismatch_d    = mismatch_q | (awg_q[14:9] != 6'(attempts_q));
          cnt_d         = {CW{1'b0}};
          state_d       = S_DECIDE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECIDE: begin
        cnt_d = {CW{1'b0}};
        if (hit_q) begin
          success_d = 1'b1;
          state_d   = S_DONE;
        end else if (attempts_q == max_q) begin
          success_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          attempts_d = attempts_q + ATT_W'(1);
          hit_d      = 1'b0;
          state_d    = S_RST;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ctrl_d = ctrl_word(state_d, cnt_d[0], routine_d, thr0_d, thr1_d);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, latches and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CW{1'b0}};
      routine_q     <= 2'd0;
      thr0_q        <= 2'd0;
      thr1_q        <= 2'd0;
      win_q         <= {CNT_W{1'b0}};
      max_q         <= {ATT_W{1'b0}};
      attempts_q    <= {ATT_W{1'b0}};
      hit_q         <= 1'b0;
      awg_q         <= 15'd0;
      ctrl_q        <= 14'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      success_q     <= 1'b0;
      last_counts_q <= 6'd0;
      last_seq_q    <= 6'd0;
      mismatch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      routine_q     <= routine_d;
      thr0_q        <= thr0_d;
      thr1_q        <= thr1_d;
      win_q         <= win_d;
      max_q         <= max_d;
      attempts_q    <= attempts_d;
      hit_q         <= hit_d;
      awg_q         <= awg_d;
      ctrl_q        <= ctrl_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      success_q     <= success_d;
      last_counts_q <= last_counts_d;
      last_seq_q    <= last_seq_d;
      mismatch_q    <= mismatch_d;
    end
  end

  assign ctrl_out     = ctrl_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign success      = success_q;
  assign attempts     = attempts_q;
  assign last_counts  = last_counts_q;
  assign last_seq     = last_seq_q;
  assign seq_mismatch = mismatch_q;

endmodule

// File: tb/tb_charge_init_sequencer.sv
// Bench for charge_init_sequencer: a cycle model of charge_control answers the control word,
// a table of runs is applied, and results are scored against expectations queued at start.
module tb_charge_init_sequencer;

  localparam int CNT_W         = 16;
  localparam int ATT_W         = 6;
  localparam int RESET_CYCLES  = 4;
  localparam int SETTLE_CYCLES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       routine = 2'd0, thr0 = 2'd0, thr1 = 2'd0;
  logic [CNT_W-1:0] count_window = '0;
  logic [ATT_W-1:0] max_attempts = '0;
  logic [14:0]      awg_in = 15'd0;
  logic [13:0]      ctrl_out;
  logic             busy, done, success, seq_mismatch;
  logic [ATT_W-1:0] attempts;
  logic [5:0]       last_counts, last_seq;

  charge_init_sequencer #(
    .CNT_W(CNT_W), .ATT_W(ATT_W), .RESET_CYCLES(RESET_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .routine(routine),
    .thr0(thr0), .thr1(thr1), .count_window(count_window), .max_attempts(max_attempts),
    .awg_in(awg_in), .ctrl_out(ctrl_out), .busy(busy), .done(done), .success(success),
    .attempts(attempts), .last_counts(last_counts), .last_seq(last_seq),
    .seq_mismatch(seq_mismatch)
  );

  always #5 clk = ~clk;

  // hit_at: count_on cycle (0-based) in which the model raises thr-hit, -1 = never;
  // hit_att: first attempt on which the hit occurs; seq_ok=0 makes the model report seq 0.
  typedef struct {
    logic [1:0] routine, thr0, thr1;
    int win, max_att, hit_at, hit_att;
    bit seq_ok;
    bit exp_success;
    int exp_att, exp_count_on, exp_last_counts, exp_last_seq;
    bit exp_mismatch;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  vec_t cur_v;
  int   n_cmp = 0, n_bad = 0;
  int   m_seq = 0, m_cnt = 0;
  bit   m_hit = 1'b0;
  int   acc_count_on = 0, acc_rst = 0, acc_seq = 0, field_err = 0;
  bit   got_done = 1'b0;
  logic prev_ctrl6 = 1'b0, prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic score_done();
    vec_t e;
    chk("done_has_expected_run", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("success", success, e.exp_success);
      chk("attempts", attempts, e.exp_att);
      chk("last_counts", last_counts, e.exp_last_counts);
      chk("last_seq", last_seq, e.exp_last_seq);
      chk("seq_mismatch", seq_mismatch, e.exp_mismatch);
      chk("count_on_cycles", acc_count_on, e.exp_count_on);
      chk("reset_cycles", acc_rst, e.exp_att * RESET_CYCLES);
      chk("seq_pulses", acc_seq, e.exp_att * (e.exp_att + 1) / 2);
      chk("ctrl_field_errors", field_err, 0);
    end else begin
      got_done = 1'b1;
    end
    got_done = 1'b1;
  endtask

  // One clock: sample after the edge, check ctrl fields, run the charge_control model, score done.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ctrl_out[3] || (ctrl_out[13:11] != 3'd0)) field_err++;
    if (busy && ((ctrl_out[5:4] != cur_v.routine) || (ctrl_out[8:7] != cur_v.thr0) ||
                 (ctrl_out[10:9] != cur_v.thr1))) field_err++;
    if (!busy && (ctrl_out != 14'd0)) field_err++;
    if (ctrl_out[1] && ctrl_out[0]) field_err++;
    if (ctrl_out[2] && !ctrl_out[0]) field_err++;
    if (ctrl_out[6] && prev_ctrl6) field_err++;
    if (done && prev_done) field_err++;
    prev_ctrl6 = ctrl_out[6];
    prev_done  = done;
    if (ctrl_out[1]) begin
      m_seq = 0; m_cnt = 0; m_hit = 1'b0; acc_rst++;
    end else begin
      if (ctrl_out[6]) begin m_seq++; acc_seq++; end
      if (ctrl_out[2]) begin
        if ((cur_v.hit_at >= 0) && (m_cnt == cur_v.hit_at) && (m_seq >= cur_v.hit_att)) m_hit = 1'b1;
        m_cnt++;
        acc_count_on++;
      end
    end
    awg_in = {(cur_v.seq_ok ? 6'(m_seq) : 6'd0), 6'(m_cnt), m_hit, 2'b00};
    if (done) score_done();
  endtask

  task automatic drive_inputs(input vec_t v);
    routine      = v.routine;
    thr0         = v.thr0;
    thr1         = v.thr1;
    count_window = CNT_W'(v.win);
    max_attempts = ATT_W'(v.max_att);
  endtask

  task automatic begin_run(input vec_t v);
    cur_v = v;
    sb.push_back(v);
    acc_count_on = 0; acc_rst = 0; acc_seq = 0; field_err = 0;
    got_done = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !got_done; i++) tick();
    chk("run_completes", got_done, 1);
  endtask

  // Full run; inputs are scrambled after acceptance and a second start is issued while busy.
  task automatic run_vec(input vec_t v);
    drive_inputs(v);
    start = 1'b1;
    begin_run(v);
    tick();
    start        = 1'b0;
    routine      = ~v.routine;
    thr0         = ~v.thr0;
    thr1         = ~v.thr1;
    count_window = CNT_W'(v.win + 3);
    max_attempts = ATT_W'(v.max_att + 2);
    for (int c = 0; c < 3000 && !got_done; c++) begin
      start = (c == 5);
      tick();
    end
    start = 1'b0;
    chk("run_completes", got_done, 1);
    tick();
    chk("idle_after_done", {done, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    // routine thr0 thr1 win max hit_at hit_att seq_ok | succ att count_on counts seq mism
    vecs[0] = '{2'b00, 2'b01, 2'b10, 100, 1, 10, 1, 1'b1, 1'b1, 1, 12, 12, 1, 1'b0};
    vecs[1] = '{2'b11, 2'b10, 2'b01, 50,  1, 5,  1, 1'b1, 1'b1, 1, 50, 50, 1, 1'b0};
    vecs[2] = '{2'b01, 2'b11, 2'b11, 20,  3, -1, 1, 1'b1, 1'b0, 3, 60, 20, 3, 1'b0};
    vecs[3] = '{2'b00, 2'b00, 2'b11, 8,   2, 3,  1, 1'b0, 1'b1, 1, 5,  5,  0, 1'b1};
    vecs[4] = '{2'b10, 2'b01, 2'b01, 0,   0, -1, 1, 1'b1, 1'b0, 1, 1,  1,  1, 1'b0};
    vecs[5] = '{2'b00, 2'b10, 2'b10, 10,  4, 2,  3, 1'b1, 1'b1, 3, 24, 4,  3, 1'b0};
    vecs[6] = '{2'b10, 2'b11, 2'b00, 6,   2, 5,  1, 1'b1, 1'b1, 1, 6,  6,  1, 1'b0};
    vecs[7] = '{2'b00, 2'b01, 2'b11, 70,  1, -1, 1, 1'b1, 1'b0, 1, 70, 6,  1, 1'b0};
    cur_v = vecs[0];

    tick();
    tick();
    chk("reset_ctrl_out", ctrl_out, 0);
    chk("reset_busy_done", {busy, done}, 0);
    chk("reset_results", {success, attempts, last_counts, last_seq, seq_mismatch}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a count window.
    r = vecs[7];
    drive_inputs(r);
    start = 1'b1;
    begin_run(r);
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && acc_count_on < 5; i++) tick();
    chk("count_window_reached", int'(acc_count_on >= 5), 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_ctrl_out", ctrl_out, 0);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_attempts", attempts, 0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0]);

    // start during DONE is ignored; start in the first IDLE cycle is accepted.
    drive_inputs(vecs[4]);
    start = 1'b1;
    begin_run(vecs[4]);
    tick();
    start = 1'b0;
    wait_done();
    drive_inputs(vecs[1]);
    start = 1'b1;
    tick();
    chk("start_in_done_ignored", busy, 0);
    begin_run(vecs[1]);
    tick();
    chk("start_on_idle_entry", busy, 1);
    start = 1'b0;
    wait_done();
    tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
